// File: rtl/bit_population_pkg.sv
// Shared types and constants for the bit population generator.
// Holds the FSM state encoding and the 16-bit LFSR definition.
package bit_population_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        OUT
    } state_e;

    localparam int          LFSR_W       = 16;
    // x^16+x^14+x^13+x^11+1 as taps on a right-shifting register
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] LFSR_PICK    = 16'h0001;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/bit_population_generator_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts right, feedback enters at the MSB.
// Advances only when en_i is high; reloads SEED on reset only.
module lfsr16
    import bit_population_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              en_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;
    logic              fb;

    always_comb begin
        fb  = ^(q_q & LFSR_TAPS);
        q_d = en_i ? {fb, q_q[LFSR_W-1:1]} : q_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bit_population_generator.sv
// Generates a WIDTH-bit word holding exactly min(count_i, WIDTH) ones,
// either packed at the LSBs or scattered by an LFSR, one bit per cycle.
module bit_population_generator
    import bit_population_pkg::*;
#(
    parameter int                WIDTH = 24,
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED,
    localparam int               CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             mode_i,
    input  logic             count_val_i,
    output logic             count_ready_o,
    output logic [WIDTH-1:0] data_o,
    output logic             data_val_o,
    input  logic             data_ready_i
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_e             state_q;
    logic               ready_q;
    logic               val_q;
    logic               mode_q;
    logic [CNT_W-1:0]   need_q;
    logic [CNT_W-1:0]   p_q;
    logic [WIDTH-1:0]   word_q;

    logic [LFSR_W-1:0]  lfsr_w;
    logic               lfsr_en;
    logic               lfsr_bit;
    logic [CNT_W-1:0]   remain_d;
    logic [CNT_W-1:0]   need_d;
    logic               bit_d;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .en_i   (lfsr_en),
        .q_o    (lfsr_w)
    );

    always_comb begin
        lfsr_en  = (state_q == FILL) && mode_q;
        lfsr_bit = |(lfsr_w & LFSR_PICK);
        remain_d = WIDTH_C - p_q;
        need_d   = (count_i > WIDTH_C) ? WIDTH_C : count_i;
        bit_d    = 1'b0;
        if (need_q == '0) begin
            bit_d = 1'b0;
        end else if (need_q == remain_d) begin
            bit_d = 1'b1;
        end else begin
            bit_d = mode_q ? lfsr_bit : 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            val_q   <= 1'b0;
            mode_q  <= 1'b0;
            need_q  <= '0;
            p_q     <= '0;
            word_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (count_val_i && ready_q) begin
                        state_q <= FILL;
                        ready_q <= 1'b0;
                        mode_q  <= mode_i;
                        need_q  <= need_d;
                        p_q     <= '0;
                        word_q  <= '0;
                    end
                end
                FILL: begin
                    // shift in at the MSB so position 0 ends at bit 0
                    word_q <= {bit_d, word_q[WIDTH-1:1]};
                    need_q <= need_q - CNT_W'(bit_d);
                    p_q    <= p_q + ONE_C;
                    if (p_q == WIDTH_C - ONE_C) begin
                        state_q <= OUT;
                        val_q   <= 1'b1;
                    end
                end
                OUT: begin
                    if (data_ready_i) begin
                        state_q <= IDLE;
                        val_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    val_q   <= 1'b0;
                end
            endcase
        end
    end

    assign count_ready_o = ready_q;
    assign data_val_o    = val_q;
    assign data_o        = word_q;

endmodule

// File: tb/tb_bit_population_generator.sv
// Directed bench for bit_population_generator at WIDTH=24.
// Table vectors plus hand sequences for stall, reset abort and streaming.
module tb_bit_population_generator;

    localparam int W = 24;
    localparam int CW = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic [CW-1:0] count = '0;
    logic          mode = 1'b0;
    logic          cval = 1'b0;
    logic          cready;
    logic [W-1:0]  data;
    logic          dval;
    logic          dready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [15:0] mlfsr = SEED;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          md;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t tab [10];

    bit_population_generator #(.WIDTH(W), .SEED(SEED)) dut (
        .clk_i         (clk),
        .arst_i        (arst),
        .count_i       (count),
        .mode_i        (mode),
        .count_val_i   (cval),
        .count_ready_o (cready),
        .data_o        (data),
        .data_val_o    (dval),
        .data_ready_i  (dready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference word from the bit-decision rules, advancing mlfsr
    task automatic model(input logic [CW-1:0] c, input logic md,
                         output logic [W-1:0] w);
        int need;
        int rem;
        logic b;
        need = (int'(c) > W) ? W : int'(c);
        w = '0;
        for (int p = 0; p < W; p++) begin
            rem = W - p;
            if (need == 0) b = 1'b0;
            else if (need == rem) b = 1'b1;
            else b = md ? mlfsr[0] : 1'b1;
            w[p] = b;
            if (b) need--;
            if (md) mlfsr = {^(mlfsr & 16'h002D), mlfsr[15:1]};
        end
    endtask

    // call at the negedge just after the request handshake edge
    task automatic wait_out(output int lat);
        lat = 1;
        while (!dval && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic request(input logic [CW-1:0] c, input logic md,
                           input int stall, output logic [W-1:0] got,
                           output logic [W-1:0] exp);
        int lat;
        logic [W-1:0] held;
        @(negedge clk);
        if (stall > 0) dready = 1'b0;
        count = c;
        mode = md;
        cval = 1'b1;
        chk("req_ready", cready, 1);
        @(posedge clk);
        @(negedge clk);
        cval = 1'b0;
        model(c, md, exp);
        wait_out(lat);
        chk("latency", lat, 25);
        got = data;
        held = data;
        for (int i = 0; i < stall; i++) begin
            cval = 1'b1;
            count = 5'd3;
            @(posedge clk);
            @(negedge clk);
            if (data !== held || !dval || cready) begin
                chk("stall_hold", {data, dval, cready}, {held, 2'b10});
            end
        end
        if (stall > 0) begin
            chk("stall_end", {data, dval, cready}, {held, 2'b10});
            cval = 1'b0;
            dready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_out", {cready, dval}, 2'b10);
    endtask

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        logic [W-1:0] first;
        int lat;
        int seen;
        int t;
        int stamps [3];

        tab[0] = '{5'd5,  1'b0, 24'h00001F};
        tab[1] = '{5'd0,  1'b0, 24'h000000};
        tab[2] = '{5'd1,  1'b0, 24'h000001};
        tab[3] = '{5'd12, 1'b0, 24'h000FFF};
        tab[4] = '{5'd23, 1'b0, 24'h7FFFFF};
        tab[5] = '{5'd24, 1'b0, 24'hFFFFFF};
        tab[6] = '{5'd31, 1'b0, 24'hFFFFFF};
        tab[7] = '{5'd0,  1'b1, 24'h000000};
        tab[8] = '{5'd24, 1'b1, 24'hFFFFFF};
        tab[9] = '{5'd31, 1'b1, 24'hFFFFFF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {cready, dval, data}, {2'b10, 24'h0});
        arst = 1'b0;

        request(5'd10, 1'b1, 0, first, exp);
        chk("first_m1", first, exp);
        chk("first_pop", $countones(first), 10);

        for (int i = 0; i < 10; i++) begin
            request(tab[i].cnt, tab[i].md, 0, got, exp);
            chk($sformatf("tab%0d", i), got, tab[i].exp);
        end

        for (int c = 0; c <= W; c++) begin
            request(CW'(c), 1'b1, 0, got, exp);
            chk($sformatf("sweep%0d", c), got, exp);
            chk($sformatf("pop%0d", c), $countones(got), c);
        end

        request(5'd7, 1'b0, 10, got, exp);
        chk("stall_word", got, 24'h00007F);
        request(5'd4, 1'b1, 0, got, exp);
        chk("after_stall", got, exp);

        // abort a mode 1 request twelve FILL cycles in
        @(negedge clk);
        count = 5'd6;
        mode = 1'b1;
        cval = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cval = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("abort_out", {cready, dval, data}, {2'b10, 24'h0});
        count = 5'd10;
        mode = 1'b1;
        cval = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        mlfsr = SEED;
        @(posedge clk);
        @(negedge clk);
        cval = 1'b0;
        model(5'd10, 1'b1, exp);
        wait_out(lat);
        chk("reset_lat", lat, 25);
        chk("reset_repeat", data, first);
        chk("reset_model", data, exp);
        @(posedge clk);
        @(negedge clk);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (dval) seen++;
        end
        chk("no_ghost_val", seen, 0);

        // streaming with count_val_i held high
        @(negedge clk);
        count = 5'd9;
        mode = 1'b1;
        cval = 1'b1;
        seen = 0;
        t = 0;
        while (seen < 3 && t < 200) begin
            @(posedge clk);
            @(negedge clk);
            t++;
            if (dval) begin
                model(5'd9, 1'b1, exp);
                chk($sformatf("stream%0d", seen), data, exp);
                stamps[seen] = t;
                seen++;
                if (seen == 3) cval = 1'b0;
            end
        end
        chk("stream_words", seen, 3);
        chk("stream_gap0", stamps[1] - stamps[0], 26);
        chk("stream_gap1", stamps[2] - stamps[1], 26);
        repeat (3) @(negedge clk);
        chk("stream_idle", {cready, dval}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
